// File: rtl/nios_timer_pkg.sv
// ---------------------------------------------------------------------------
// nios_timer_pkg
// Shared constants for the multi-channel interval timer.
//   - Register offsets within a channel's address slot.
//   - Bit positions inside STATUS and CONTROL.
//   - Address-width helper. Optional macro TIMER_PRESCALE_EN adds a global
//     PRESCALE register and may widen the address by one bit.
// ---------------------------------------------------------------------------
package nios_timer_pkg;

  // Width of the register field at the bottom of the word address.
  localparam int REG_W = 2;

  typedef enum logic [REG_W-1:0] {
    REG_STATUS   = 2'd0,
    REG_CONTROL  = 2'd1,
    REG_PERIOD   = 2'd2,
    REG_SNAPSHOT = 2'd3
  } reg_sel_e;

  // STATUS bits
  localparam int STAT_TO  = 0;
  localparam int STAT_RUN = 1;

  // CONTROL bits (ITO/CONT are stored; START/STOP are write-only strobes)
  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam int PRESCALE_W = 16;

`ifdef TIMER_PRESCALE_EN
  localparam bit PRESCALE_EN = 1'b1;
`else
  localparam bit PRESCALE_EN = 1'b0;
`endif

  // Width of the channel field of the address. PRESCALE sits at the very top
  // of the channel space, so a fully populated channel space needs one more bit.
  function automatic int ch_addr_w(input int num_ch);
    int ch_bits;
    ch_bits = $clog2(num_ch);
    if (PRESCALE_EN && num_ch >= (1 << ch_bits)) ch_bits = ch_bits + 1;
    return ch_bits;
  endfunction

endpackage

// File: rtl/nios_timer_channel.sv
// ---------------------------------------------------------------------------
// nios_timer_channel
// One down-counting timer channel: counter, period, RUN/TO, stored control
// bits (CONT, ITO) and a counter snapshot.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   tick                 count enable (prescaler output or constant 1)
//   wr_en, wr_reg,       register write strobe for this channel, register
//   wr_data              field and data
//   rd_reg, rd_data      combinational read of the selected register
//   irq                  TO && ITO
// ---------------------------------------------------------------------------
module nios_timer_channel
  import nios_timer_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter int          DATA_W       = 32,
  parameter logic [31:0] RESET_PERIOD = 32'hC34F
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              wr_en,
  input  logic [REG_W-1:0]  wr_reg,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [REG_W-1:0]  rd_reg,
  output logic [DATA_W-1:0] rd_data,
  output logic              irq
);

  localparam logic [CNT_W-1:0] RST_CNT = RESET_PERIOD[CNT_W-1:0];

  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] snapshot;
  logic [1:0]       ctrl;      // {CONT, ITO}
  logic             run;
  logic             to;
  logic             timeout;

  assign timeout = run && tick && (counter == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      counter  <= RST_CNT;
      period   <= RST_CNT;
      snapshot <= '0;
      ctrl     <= '0;
      run      <= 1'b0;
      to       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments mean every right-hand side sees the
      // pre-edge state: host writes placed after the counting code override
      // it, and SNAPSHOT captures the count from before this edge's update.
      if (run && tick) begin
        if (timeout) begin
          counter <= period;
          run     <= ctrl[CTRL_CONT];
        end else begin
          counter <= counter - CNT_W'(1);
        end
      end

      // A timeout on the same edge as a STATUS write leaves TO set.
      if (timeout)                              to <= 1'b1;
      else if (wr_en && wr_reg == REG_STATUS)   to <= 1'b0;

      if (wr_en) begin
        case (wr_reg)
          REG_CONTROL: begin
            ctrl <= wr_data[CTRL_CONT:CTRL_ITO];
            if (wr_data[CTRL_START])     run <= 1'b1;
            else if (wr_data[CTRL_STOP]) run <= 1'b0;
          end
          REG_PERIOD: begin
            // Force a reload: the new period takes effect immediately.
            period  <= wr_data[CNT_W-1:0];
            counter <= wr_data[CNT_W-1:0];
            run     <= 1'b0;
          end
          REG_SNAPSHOT: snapshot <= counter;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns rd_data and no latch forms.
    rd_data = '0;
    case (rd_reg)
      REG_STATUS: begin
        rd_data[STAT_RUN] = run;
        rd_data[STAT_TO]  = to;
      end
      REG_CONTROL:  rd_data[CTRL_CONT:CTRL_ITO] = ctrl;
      REG_PERIOD:   rd_data[CNT_W-1:0] = period;
      REG_SNAPSHOT: rd_data[CNT_W-1:0] = snapshot;
      default: ;
    endcase
  end

  assign irq = to & ctrl[CTRL_ITO];

endmodule

// File: rtl/nios_multi_timer.sv
// ---------------------------------------------------------------------------
// nios_multi_timer
// NUM_CH-channel interval timer on an Avalon-MM slave. The top level decodes
// {channel, reg} word addresses, holds the optional prescaler, registers the
// read data and ORs the per-channel interrupts.
// Optional feature macro: TIMER_PRESCALE_EN -- global 16-bit PRESCALE
// register at the highest word address; otherwise every cycle is a tick.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   address               word address {channel, reg[1:0]}
//   chipselect, write_n   slave select, active-low write strobe
//   writedata             write data
//   readdata              registered read data, one cycle latency
//   irq_ch                per-channel interrupt (TO && ITO)
//   irq                   OR of irq_ch
// ---------------------------------------------------------------------------
module nios_multi_timer
  import nios_timer_pkg::*;
#(
  parameter int          NUM_CH       = 4,
  parameter int          CNT_W        = 32,
  parameter int          DATA_W       = 32,
  parameter logic [31:0] RESET_PERIOD = 32'hC34F,
  localparam int         ADDR_W       = ch_addr_w(NUM_CH) + REG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic [NUM_CH-1:0] irq_ch,
  output logic              irq
);

  logic [ADDR_W-1:0] ch_sel;
  logic              wr_strobe;
  logic              tick;
  logic [DATA_W-1:0] ch_rd [NUM_CH];
  logic [DATA_W-1:0] rd_next;

  assign ch_sel    = address >> REG_W;
  assign wr_strobe = chipselect && !write_n;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    nios_timer_channel #(
      .CNT_W        (CNT_W),
      .DATA_W       (DATA_W),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .wr_en   (wr_strobe && ch_sel == ADDR_W'(i)),
      .wr_reg  (address[REG_W-1:0]),
      .wr_data (writedata),
      .rd_reg  (address[REG_W-1:0]),
      .rd_data (ch_rd[i]),
      .irq     (irq_ch[i])
    );
  end

`ifdef TIMER_PRESCALE_EN
  localparam logic [ADDR_W-1:0] PRESCALE_ADDR = '1;

  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] pre_cnt;

  // Prescale counter runs 0..prescale and ticks on the wrap.
  assign tick = (pre_cnt == prescale);

  always_ff @(posedge clk) begin
    if (reset) begin
      prescale <= '0;
      pre_cnt  <= '0;
    end else if (wr_strobe && address == PRESCALE_ADDR) begin
      prescale <= writedata[PRESCALE_W-1:0];
      pre_cnt  <= '0;
    end else if (tick) begin
      pre_cnt  <= '0;
    end else begin
      pre_cnt  <= pre_cnt + PRESCALE_W'(1);
    end
  end
`else
  assign tick = 1'b1;
`endif

  // Channels outside 0..NUM_CH-1 fall through to zero.
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == ADDR_W'(i)) rd_next = ch_rd[i];
    end
`ifdef TIMER_PRESCALE_EN
    if (address == PRESCALE_ADDR) rd_next = DATA_W'(prescale);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_next;
  end

  assign irq = |irq_ch;

endmodule
